// File: rtl/game_beam_gen.sv
// Raster timing for a centred, integer-upscaled game window on a VGA display.
// Produces game beam coordinates and aligns the game's returned colour with the sync outputs.
module game_beam_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int GAME_W      = 224,
  parameter int GAME_H      = 288,
  parameter int SCALE       = 1,
  parameter int RGB_LATENCY = 2,
  parameter int SYNC_NEG    = 1
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst,
  input  logic [3:0]                game_R,
  input  logic [3:0]                game_G,
  input  logic [3:0]                game_B,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb,
  output logic                      display_enabled,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic [3:0]                VGA_R,
  output logic [3:0]                VGA_G,
  output logic [3:0]                VGA_B
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_OFF    = (H_VISIBLE - GAME_W * SCALE) / 2;
  localparam int V_OFF    = (V_VISIBLE - GAME_H * SCALE) / 2;
  localparam int H_END    = H_OFF + GAME_W * SCALE;
  localparam int V_END    = V_OFF + GAME_H * SCALE;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int XW       = $clog2(GAME_W);
  localparam int YW       = $clog2(GAME_H);
  localparam int SW       = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic SYNC_INACTIVE = (SYNC_NEG != 0);

  logic [HW-1:0] hc_reg, hc_next;
  logic [VW-1:0] vc_reg, vc_next;
  logic [SW-1:0] subx_reg, suby_reg;
  logic [XW-1:0] gx_reg;
  logic [YW-1:0] gy_reg;
  logic          line_end, win_h, win_v, win, hs_act, vs_act;

  // Each stage carries {win, hs_act, vs_act}; stage 0 is level with the beam outputs.
  logic [RGB_LATENCY:0][2:0] pipe_reg;
  logic [2:0]                tail;

  always_comb begin
    line_end = (hc_reg == HW'(H_TOTAL - 1));
    hc_next  = line_end ? '0 : hc_reg + 1'b1;
    vc_next  = vc_reg;
    if (line_end) begin
      vc_next = (vc_reg == VW'(V_TOTAL - 1)) ? '0 : vc_reg + 1'b1;
    end
    win_h  = (hc_reg >= HW'(H_OFF)) && (hc_reg < HW'(H_END));
    win_v  = (vc_reg >= VW'(V_OFF)) && (vc_reg < VW'(V_END));
    win    = win_h && win_v;
    hs_act = (hc_reg >= HW'(HS_START)) && (hc_reg < HW'(HS_END));
    vs_act = (vc_reg >= VW'(VS_START)) && (vc_reg < VW'(VS_END));
  end

  // Raster counters plus the game-pixel sub-counters that track the current position.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hc_reg   <= '0;
      vc_reg   <= '0;
      subx_reg <= '0;
      suby_reg <= '0;
      gx_reg   <= '0;
      gy_reg   <= '0;
    end else begin
      hc_reg <= hc_next;
      vc_reg <= vc_next;
      if (hc_next == HW'(H_OFF)) begin
        subx_reg <= '0;
        gx_reg   <= '0;
      end else if (win_h) begin
        if (subx_reg == SW'(SCALE - 1)) begin
          subx_reg <= '0;
          gx_reg   <= gx_reg + 1'b1;
        end else begin
          subx_reg <= subx_reg + 1'b1;
        end
      end
      if (line_end) begin
        if (vc_next == VW'(V_OFF)) begin
          suby_reg <= '0;
          gy_reg   <= '0;
        end else if (win_v) begin
          if (suby_reg == SW'(SCALE - 1)) begin
            suby_reg <= '0;
            gy_reg   <= gy_reg + 1'b1;
          end else begin
            suby_reg <= suby_reg + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      sx              <= '0;
      sy              <= '0;
      display_enabled <= 1'b0;
      game_pix_stb    <= 1'b0;
      frame_stb       <= 1'b0;
    end else begin
      sx              <= win ? gx_reg : '0;
      sy              <= win ? gy_reg : '0;
      display_enabled <= win;
      game_pix_stb    <= win && (subx_reg == '0);
      frame_stb       <= (hc_reg == HW'(H_OFF)) && (vc_reg == VW'(V_OFF));
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg[0] <= {win, hs_act, vs_act};
      for (int i = 1; i <= RGB_LATENCY; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  // The game's colour arrives in the same cycle as the last stage, so both are registered together.
  assign tail = pipe_reg[RGB_LATENCY];

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= SYNC_INACTIVE;
      VGA_VS <= SYNC_INACTIVE;
    end else begin
      VGA_R  <= tail[2] ? game_R : '0;
      VGA_G  <= tail[2] ? game_G : '0;
      VGA_B  <= tail[2] ? game_B : '0;
      VGA_HS <= tail[1] ^ SYNC_INACTIVE;
      VGA_VS <= tail[0] ^ SYNC_INACTIVE;
    end
  end

endmodule

// File: doc/game_beam_gen.md
# game_beam_gen

Timing source for the game renderer and its VGA output stage. It scans the physical 640x480 raster and produces the beam signals that the game consumes: game coordinates `sx`/`sy`, `game_pix_stb`, `frame_stb` and `display_enabled`, all inside a centred, integer-upscaled 224x288 game window. It takes back the game's 12-bit colour after a fixed pipeline delay, aligns `VGA_HS`/`VGA_VS` to that colour, and blanks everything outside the window.

## Interface
Parameters:
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: horizontal sync width
- `H_BACK`, 48: horizontal back porch
- `V_VISIBLE`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vertical sync width
- `V_BACK`, 33: vertical back porch
- `GAME_W`, 224: game width in game pixels
- `GAME_H`, 288: game height in game pixels
- `SCALE`, 1: physical pixels per game pixel on each axis, 1..4. Requires `GAME_W*SCALE <= H_VISIBLE` and `GAME_H*SCALE <= V_VISIBLE`.
- `RGB_LATENCY`, 2: cycles from beam outputs to valid `game_R/G/B`, 1..8
- `SYNC_NEG`, 1: 1 means the sync pulses are active-low

Ports:
- `vga_pix_clk`  in  1  single clock for the whole block
- `rst`  in  1  reset, synchronous and active-high
- `game_R`, `game_G`, `game_B`  in  4 each  game colour for the beam position issued `RGB_LATENCY` cycles earlier
- `sx`  out  `$clog2(GAME_W)`  game x coordinate
- `sy`  out  `$clog2(GAME_H)`  game y coordinate
- `game_pix_stb`  out  1  high on the first physical pixel of each game pixel
- `frame_stb`  out  1  one-cycle pulse at game position (0,0)
- `display_enabled`  out  1  beam is inside the game window
- `VGA_HS`, `VGA_VS`  out  1 each  sync outputs
- `VGA_R`, `VGA_G`, `VGA_B`  out  4 each  colour to the DAC

## Operation
- Counters:
  - `hc` runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800 with defaults).
  - `vc` runs 0..V_TOTAL-1 (525 with defaults) and advances when `hc` wraps. `vc` wraps to 0 after V_TOTAL-1.
  - Line layout is visible, front porch, sync, back porch.
  - HS is active for `hc` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC); VS uses the same rule on `vc`.
- Window:
  - H_OFF = (H_VISIBLE-GAME_W*SCALE)/2 and V_OFF = (V_VISIBLE-GAME_H*SCALE)/2. With defaults these are 208 and 96.
  - `win` = `hc` in [H_OFF, H_OFF+GAME_W*SCALE) and `vc` in [V_OFF, V_OFF+GAME_H*SCALE).
- Scaling:
  - Sub-counter `subx` runs 0..SCALE-1 inside the window and is cleared at the start of each line's window.
  - The game x counter increments when `subx` wraps.
  - `suby` and the game y counter behave the same way per line, and are cleared at `vc`==V_OFF.
- Beam stage, registered from the counters:
  - `sx`/`sy` carry the game coordinates inside the window and are 0 outside it.
  - `display_enabled` = `win`.
  - `game_pix_stb` = `win` && `subx`==0.
  - `frame_stb` = (`hc`==H_OFF && `vc`==V_OFF). It pulses once per frame, in the same cycle that `sx`==`sy`==0 and `display_enabled` rises.
- Output stage:
  - A shift register of depth `RGB_LATENCY` carries `win`, HS-active and VS-active.
  - On the final register, `VGA_R/G/B` = `game_*` when the delayed `win` is 1, else 0.
  - `VGA_HS`/`VGA_VS` = delayed active XOR `SYNC_NEG`.
- Reset:
  - All counters, sub-counters and `sx`/`sy` go to 0. `game_pix_stb`, `frame_stb`, `display_enabled` and `VGA_R/G/B` go to 0.
  - `VGA_HS`/`VGA_VS` go to their inactive level (1 when `SYNC_NEG`=1).
  - Every pipeline stage is flushed to inactive.
  - Reset asserted mid-frame takes effect on the next edge. The scan restarts at (`hc`,`vc`)=(0,0) in the first cycle after `rst` falls.

## Timing
- Beam outputs lag the counter position by 1 cycle.
- `VGA_*` outputs lag the counter position by `RGB_LATENCY`+2 cycles. HS, VS and colour stay mutually aligned.
- Frame period is H_TOTAL*V_TOTAL cycles (420000 with defaults). `frame_stb` has exactly this period.
- `sx` changes every SCALE cycles inside a line. `sy` changes every SCALE lines.
- There is no handshake. The game must present colour exactly `RGB_LATENCY` cycles after the beam; nothing is stalled or backpressured.

## Test plan
- Reset and sync: hold `rst` 5 cycles then release, with defaults. Required:
  - Before release, all outputs are 0 except `VGA_HS`=`VGA_VS`=1.
  - After release, `VGA_HS` goes low for 96 cycles every 800 cycles.
  - `VGA_VS` goes low for 2 lines every 525 lines.
- Beam window, defaults: `frame_stb` pulses once every 420000 cycles, 1 cycle after counter position (208,96). In the same cycle `sx`=0, `sy`=0 and `display_enabled`=1. `sx` then counts to 223 on each of 288 lines, and `display_enabled` is high for exactly 64512 cycles per frame.
- Scaling, `SCALE`=2 with small custom timing (H 64/2/4/2, V 40/1/1/1, GAME 16x12): `game_pix_stb` asserts every other window cycle. Each `sx` value is held 2 cycles and each `sy` value 2 lines. Window starts at `hc`=16 and `vc`=8.
- Colour alignment, `RGB_LATENCY`=2: a model echoes `game_R`=`sx[3:0]` after 2 cycles. Required:
  - `VGA_R` is 0 outside the window.
  - `VGA_R` equals the `sx[3:0]` pattern inside the window, starting exactly 4 cycles after counter `hc`=H_OFF.
  - The `VGA_HS` falling edge lands 4 cycles after counter `hc`=656.
- Mid-frame reset: assert `rst` for 1 cycle at `vc`=300. Required: the pipeline is flushed and `VGA_R`=0 on the next cycles; `frame_stb` next pulses 1 cycle after the restarted scan reaches (208,96), i.e. 96*800+208+1 cycles after `rst` falls.
- Sweep `RGB_LATENCY` = 1 and 8: HS, VS and colour stay mutually aligned, and the beam-to-`VGA` offset equals `RGB_LATENCY`+1 cycles.
